// File: rtl/lfsr_noise_checker.sv
// lfsr_noise_checker
// Tracks a received 32-bit Galois LFSR noise stream against a local reference.
// It acquires lock after a run of good samples, tolerates single-sample drops
// by realigning one step ahead, declares a sticky loss after a run of misses,
// and keeps saturating error and sample statistics.
module lfsr_noise_checker #(
    parameter int          DATA_WIDTH  = 16,
    parameter logic [31:0] SEED        = 32'hACE1_2345,
    parameter logic [31:0] POLY_MASK   = 32'h8020_0003,
    parameter int          LOCK_COUNT  = 4,
    parameter int          LOSS_THRESH = 8,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] noise_in,
    input  logic                  valid_in,
    input  logic                  resync,
    input  logic                  clear_stats,
    output logic                  locked,
    output logic                  lost,
    output logic                  err_pulse,
    output logic                  slip_pulse,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  sample_count
);

    localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    localparam logic [1:0] ST_ACQ    = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_LOST   = 2'd2;

    // One Galois step of the generator.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY_MASK : 32'h0000_0000);
    endfunction

    // The generator emits the most significant DATA_WIDTH bits of its state.
    function automatic logic [DATA_WIDTH-1:0] lfsr_top(input logic [31:0] s);
        return s[31 -: DATA_WIDTH];
    endfunction

    localparam logic [31:0] R_INIT = lfsr_next(SEED);

    logic [31:0]           r_q, r_d;
    logic [1:0]            state_q, state_d;
    logic [RUN_W-1:0]      run_q, run_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic                  locked_q, locked_d;
    logic                  lost_q, lost_d;
    logic                  err_pulse_q, err_pulse_d;
    logic                  slip_pulse_q, slip_pulse_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_WIDTH-1:0]  samp_cnt_q, samp_cnt_d;

    logic [31:0]           r_step1_s;
    logic [31:0]           r_step2_s;
    logic                  is_match_s;
    logic                  is_slip_s;
    logic                  is_miss_s;
    logic [RUN_W-1:0]      run_inc_s;
    logic [MISS_W-1:0]     miss_inc_s;

    // Compare the sample against the expected word and its one-step-ahead alternate.
    always_comb begin
        r_step1_s  = lfsr_next(r_q);
        r_step2_s  = lfsr_next(r_step1_s);
        is_match_s = (noise_in == lfsr_top(r_q));
        is_slip_s  = !is_match_s && (noise_in == lfsr_top(r_step1_s));
        is_miss_s  = !is_match_s && !is_slip_s;
        run_inc_s  = run_q + RUN_W'(1);
        miss_inc_s = miss_q + MISS_W'(1);
    end

    // Next-state logic: reference advance, lock FSM, pulses and statistics.
    always_comb begin
        r_d          = r_q;
        state_d      = state_q;
        run_d        = run_q;
        miss_d       = miss_q;
        err_pulse_d  = 1'b0;
        slip_pulse_d = 1'b0;
        err_cnt_d    = err_cnt_q;
        samp_cnt_d   = samp_cnt_q;

        if (resync) begin
            // Restart acquisition; any same-cycle sample is discarded.
            r_d     = R_INIT;
            state_d = ST_ACQ;
            run_d   = {RUN_W{1'b0}};
            miss_d  = {MISS_W{1'b0}};
        end else if (valid_in) begin
            if (is_slip_s) begin
                r_d          = r_step2_s;
                slip_pulse_d = 1'b1;
            end else begin
                r_d          = r_step1_s;
                err_pulse_d  = is_miss_s;
            end

            if (samp_cnt_q != {CNT_WIDTH{1'b1}}) begin
                samp_cnt_d = samp_cnt_q + CNT_WIDTH'(1);
            end else begin
                samp_cnt_d = samp_cnt_q;
            end

            if (is_miss_s && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
                err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end

            case (state_q)
                ST_ACQ: begin
                    if (is_miss_s) begin
                        run_d = {RUN_W{1'b0}};
                    end else if (run_inc_s == RUN_W'(LOCK_COUNT)) begin
                        state_d = ST_LOCKED;
                        run_d   = {RUN_W{1'b0}};
                        miss_d  = {MISS_W{1'b0}};
                    end else begin
                        run_d = run_inc_s;
                    end
                end
                ST_LOCKED: begin
                    if (!is_miss_s) begin
                        miss_d = {MISS_W{1'b0}};
                    end else if (miss_inc_s == MISS_W'(LOSS_THRESH)) begin
                        state_d = ST_LOST;
                        miss_d  = {MISS_W{1'b0}};
                    end else begin
                        miss_d = miss_inc_s;
                    end
                end
                ST_LOST: begin
                    state_d = ST_LOST;
                end
                default: begin
                    // Unreachable encoding: fall back to a fresh acquisition.
                    state_d = ST_ACQ;
                    run_d   = {RUN_W{1'b0}};
                    miss_d  = {MISS_W{1'b0}};
                end
            endcase
        end else begin
            // Idle cycle: hold everything, pulses stay low.
            r_d = r_q;
        end

        if (clear_stats) begin
            err_cnt_d  = {CNT_WIDTH{1'b0}};
            samp_cnt_d = {CNT_WIDTH{1'b0}};
        end else begin
            err_cnt_d  = err_cnt_d;
            samp_cnt_d = samp_cnt_d;
        end

        locked_d = (state_d == ST_LOCKED);
        lost_d   = (state_d == ST_LOST);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q          <= R_INIT;
            state_q      <= ST_ACQ;
            run_q        <= {RUN_W{1'b0}};
            miss_q       <= {MISS_W{1'b0}};
            locked_q     <= 1'b0;
            lost_q       <= 1'b0;
            err_pulse_q  <= 1'b0;
            slip_pulse_q <= 1'b0;
            err_cnt_q    <= {CNT_WIDTH{1'b0}};
            samp_cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            r_q          <= r_d;
            state_q      <= state_d;
            run_q        <= run_d;
            miss_q       <= miss_d;
            locked_q     <= locked_d;
            lost_q       <= lost_d;
            err_pulse_q  <= err_pulse_d;
            slip_pulse_q <= slip_pulse_d;
            err_cnt_q    <= err_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
        end
    end

    assign locked       = locked_q;
    assign lost         = lost_q;
    assign err_pulse    = err_pulse_q;
    assign slip_pulse   = slip_pulse_q;
    assign err_count    = err_cnt_q;
    assign sample_count = samp_cnt_q;

endmodule

// File: tb/tb_lfsr_noise_checker.sv
// Directed bench for lfsr_noise_checker. Stream words are precomputed by hand
// from SEED=0xACE12345 and mask 0x80200003 (top 16 bits of successive states).
// Counters are narrowed to 4 bits so saturation is reachable quickly.
module tb_lfsr_noise_checker;

    localparam int DW = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] noise_in;
    logic          valid_in;
    logic          resync;
    logic          clear_stats;
    logic          locked;
    logic          lost;
    logic          err_pulse;
    logic          slip_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] sample_count;

    int checks_q;
    int failures_q;

    // Stream words R0..R14 (top 16 bits of nxt^k(SEED), k = 1..15).
    logic [15:0] stream [0:14];

    lfsr_noise_checker #(
        .DATA_WIDTH (DW),
        .SEED       (32'hACE1_2345),
        .POLY_MASK  (32'h8020_0003),
        .LOCK_COUNT (4),
        .LOSS_THRESH(8),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .noise_in    (noise_in),
        .valid_in    (valid_in),
        .resync      (resync),
        .clear_stats (clear_stats),
        .locked      (locked),
        .lost        (lost),
        .err_pulse   (err_pulse),
        .slip_pulse  (slip_pulse),
        .err_count   (err_count),
        .sample_count(sample_count)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_q++;
        if (obs !== exp) begin
            failures_q++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic lk, input logic ls,
                             input logic ep, input logic sp, input int ec, input int sc);
        check_val({tag, ".locked"},     {31'd0, locked},     {31'd0, lk});
        check_val({tag, ".lost"},       {31'd0, lost},       {31'd0, ls});
        check_val({tag, ".err_pulse"},  {31'd0, err_pulse},  {31'd0, ep});
        check_val({tag, ".slip_pulse"}, {31'd0, slip_pulse}, {31'd0, sp});
        check_val({tag, ".err_count"},  {28'd0, err_count},  ec);
        check_val({tag, ".sample_count"}, {28'd0, sample_count}, sc);
    endtask

    // Apply one cycle of inputs starting at a falling edge; returns at the next falling edge.
    task automatic drive(input logic v, input logic [15:0] d, input logic rs, input logic cs);
        valid_in    = v;
        noise_in    = d;
        resync      = rs;
        clear_stats = cs;
        @(posedge clk);
        @(negedge clk);
        valid_in    = 1'b0;
        resync      = 1'b0;
        clear_stats = 1'b0;
        noise_in    = 16'h0000;
    endtask

    initial begin
        checks_q   = 0;
        failures_q = 0;
        stream[0]  = 16'hD650; stream[1]  = 16'hEB08; stream[2]  = 16'hF5A4;
        stream[3]  = 16'h7AD2; stream[4]  = 16'hBD49; stream[5]  = 16'hDE84;
        stream[6]  = 16'hEF62; stream[7]  = 16'h77B1; stream[8]  = 16'h3BD8;
        stream[9]  = 16'h9DCC; stream[10] = 16'hCEC6; stream[11] = 16'h6763;
        stream[12] = 16'hB391; stream[13] = 16'h59C8; stream[14] = 16'hACC4;

        rst_n = 1'b0; valid_in = 1'b0; noise_in = 16'h0000; resync = 1'b0; clear_stats = 1'b0;
        @(negedge clk);

        // Reset with valid asserted.
        drive(1'b1, 16'h1234, 1'b0, 1'b0);
        drive(1'b1, 16'hD650, 1'b0, 1'b0);
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;

        // Acquisition: four good samples give lock.
        drive(1'b1, stream[0], 1'b0, 1'b0);
        check_all("acq1", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        drive(1'b1, stream[1], 1'b0, 1'b0);
        drive(1'b1, stream[2], 1'b0, 1'b0);
        check_all("acq3", 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
        drive(1'b1, stream[3], 1'b0, 1'b0);
        check_all("acq4", 1'b1, 1'b0, 1'b0, 1'b0, 0, 4);

        // Idle cycle changes nothing.
        drive(1'b0, stream[4], 1'b0, 1'b0);
        check_all("idle", 1'b1, 1'b0, 1'b0, 1'b0, 0, 4);

        // Dropped sample (R4 skipped): slip realigns, not an error.
        drive(1'b1, stream[5], 1'b0, 1'b0);
        check_all("slip", 1'b1, 1'b0, 1'b0, 1'b1, 0, 5);
        drive(1'b1, stream[6], 1'b0, 1'b0);
        check_all("after_slip", 1'b1, 1'b0, 1'b0, 1'b0, 0, 6);

        // Seven misses then a good sample: stays locked (R advances to R14).
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 16'h0000, 1'b0, 1'b0);
            check_val("miss7.err_pulse", {31'd0, err_pulse}, 32'd1);
        end
        check_all("miss7", 1'b1, 1'b0, 1'b1, 1'b0, 7, 13);
        drive(1'b1, stream[14], 1'b0, 1'b0);
        check_all("miss7_good", 1'b1, 1'b0, 1'b0, 1'b0, 7, 14);

        // Clear stats without a sample.
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        check_all("clear", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Eight consecutive misses: loss.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 16'h0000, 1'b0, 1'b0);
        end
        check_all("loss7", 1'b1, 1'b0, 1'b1, 1'b0, 7, 7);
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        check_all("loss8", 1'b0, 1'b1, 1'b1, 1'b0, 8, 8);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check_all("lost_sticky", 1'b0, 1'b1, 1'b0, 1'b0, 8, 8);

        // Resync beats a same-cycle sample; counters retained; relock after four.
        drive(1'b1, stream[0], 1'b1, 1'b0);
        check_all("resync", 1'b0, 1'b0, 1'b0, 1'b0, 8, 8);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, stream[i], 1'b0, 1'b0);
        end
        check_all("reacq3", 1'b0, 1'b0, 1'b0, 1'b0, 8, 11);
        drive(1'b1, stream[3], 1'b0, 1'b0);
        check_all("reacq4", 1'b1, 1'b0, 1'b0, 1'b0, 8, 12);

        // Clear overrides a same-cycle mismatch increment; pulse still fires.
        drive(1'b1, 16'h0000, 1'b0, 1'b1);
        check_all("clear_miss", 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

        // Saturation of both 4-bit counters.
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 16'h0000, 1'b0, 1'b0);
        end
        check_all("sat15", 1'b0, 1'b1, 1'b1, 1'b0, 15, 15);
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        check_all("sat16", 1'b0, 1'b1, 1'b1, 1'b0, 15, 15);

        // Mid-stream reset with valid high.
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b1, stream[0], 1'b0, 1'b0);
        drive(1'b1, stream[1], 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, stream[2], 1'b0, 1'b0);
        check_all("midrst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;

        // After reset: R0 match, then R2 slips over R1, then R3, R4 complete lock.
        drive(1'b1, stream[0], 1'b0, 1'b0);
        check_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
        drive(1'b1, stream[2], 1'b0, 1'b0);
        check_all("acq_slip", 1'b0, 1'b0, 1'b0, 1'b1, 0, 2);
        drive(1'b1, stream[3], 1'b0, 1'b0);
        check_all("acq_slip_next", 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
        drive(1'b1, stream[4], 1'b0, 1'b0);
        check_all("acq_slip_lock", 1'b1, 1'b0, 1'b0, 1'b0, 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule
